piso_tx_scheduler: RTL and testbench

Round-robin transmit scheduler that shares one parallel-in/serial-out serializer among NREQ requesters. Each requester offers a WIDTH-bit word with a valid/ready handshake; the block grants one requester at a time, loads its word, shifts it out LSB-first on a single serial line with a frame strobe, then inserts an idle gap before the next grant. It sits between the parallel producers and the serial link in the serial-transmit path.

---
 rtl/piso_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_piso_tx_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one LSB-first serializer among NREQ requesters.
// Each frame: grant in IDLE, capture in LOAD, WIDTH bits in SHIFT, GAP idle cycles.
module piso_tx_scheduler #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  parameter  int GAP   = 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req_Valid,
  input  logic [NREQ*WIDTH-1:0] Req_Data,
  output logic [NREQ-1:0]       Req_Ready,
  output logic                  SOut,
  output logic                  Frame,
  output logic [IDW-1:0]        Grant_Id,
  output logic                  Done,
  output logic                  Busy
);

  localparam int CMAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [NREQ-1:0] ONE_HOT  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic              sout_q, sout_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [IDW-1:0]    sel_s;
  logic [IDW-1:0]    idx_s;
  logic              hit_s;
  logic [WIDTH-1:0]  word_s;

  assign word_s = Req_Data[int'(grant_q)*WIDTH +: WIDTH];

  // First valid requester strictly after the pointer, wrapping; the last served ranks lowest.
  always_comb begin
    sel_s = '0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IDW'((int'(ptr_q) + k) % NREQ);
      if (!hit_s && Req_Valid[idx_s]) begin
        hit_s = 1'b1;
        sel_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    sout_d  = sout_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_LOAD;
          ptr_d   = sel_s;
          grant_d = sel_s;
          ready_d = ONE_HOT << sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sout_d  = word_s[0];
        frame_d = 1'b1;
        shreg_d = {1'b0, word_s[WIDTH-1:1]};
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          sout_d  = 1'b0;
          frame_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          sout_d  = shreg_q[0];
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = 1'b0;
        frame_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      grant_q <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      sout_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Req_Ready = ready_q;
  assign SOut      = sout_q;
  assign Frame     = frame_q;
  assign Grant_Id  = grant_q;
  assign Done      = done_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler: a GAP=1 instance (a_*) and a GAP=0 instance (b_*).
module tb_piso_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_at = 0;

  logic [3:0]  a_valid, b_valid;
  logic [15:0] a_data, b_data;
  logic [3:0]  a_ready, b_ready;
  logic        a_sout, a_frame, a_done, a_busy;
  logic        b_sout, b_frame, b_done, b_busy;
  logic [1:0]  a_grant, b_grant;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_tx_scheduler #(.WIDTH(4), .NREQ(4), .GAP(1)) dut_a (
    .Clock(clk), .Reset(rst_n), .Req_Valid(a_valid), .Req_Data(a_data),
    .Req_Ready(a_ready), .SOut(a_sout), .Frame(a_frame), .Grant_Id(a_grant),
    .Done(a_done), .Busy(a_busy));

  piso_tx_scheduler #(.WIDTH(4), .NREQ(4), .GAP(0)) dut_b (
    .Clock(clk), .Reset(rst_n), .Req_Valid(b_valid), .Req_Data(b_data),
    .Req_Ready(b_ready), .SOut(b_sout), .Frame(b_frame), .Grant_Id(b_grant),
    .Done(b_done), .Busy(b_busy));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until a Ready pulse is visible; at returns the cycle it appeared.
  task automatic wait_ready(input bit use_b, output int at);
    bit got;
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if ((use_b ? b_ready : a_ready) != 4'b0000) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    if (!got) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called in the Ready cycle; checks grant, the four serial bits and the Done cycle.
  task automatic frame_check(input bit use_b, input int g, input logic [3:0] w,
                             input bit apply_mid, input logic [3:0] mid_valid);
    check_eq("ready_onehot", use_b ? b_ready : a_ready, 32'(4'b0001 << g));
    check_eq("grant_id", use_b ? b_grant : a_grant, 32'(g));
    check_eq("frame_low_load", use_b ? b_frame : a_frame, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (apply_mid && k == 1) a_valid = mid_valid;
      check_eq("sout_bit", use_b ? b_sout : a_sout, 32'(w[k]));
      check_eq("frame_high", use_b ? b_frame : a_frame, 32'd1);
      check_eq("ready_quiet", use_b ? b_ready : a_ready, 32'd0);
    end
    tick();
    check_eq("done_pulse", use_b ? b_done : a_done, 32'd1);
    check_eq("frame_low_done", use_b ? b_frame : a_frame, 32'd0);
    check_eq("busy_at_done", use_b ? b_busy : a_busy, use_b ? 32'd0 : 32'd1);
  endtask

  task automatic next_frame(input bit use_b, input int g, input logic [3:0] w, input int period,
                            input bit apply_mid, input logic [3:0] mid_valid);
    int at;
    wait_ready(use_b, at);
    if (period > 0) check_eq("frame_period", 32'(at - last_at), 32'(period));
    last_at = at;
    frame_check(use_b, g, w, apply_mid, mid_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    rst_n   = 1'b0;
    a_valid = 4'b0000;
    b_valid = 4'b0000;
    a_data  = 16'h0000;
    b_data  = 16'h0000;
    tick();
    tick();
    check_eq("reset_outputs", {a_ready, a_sout, a_frame, a_done, a_busy, a_grant}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_outputs", {a_ready, a_sout, a_frame, a_done, a_busy, a_grant}, 32'd0);
    end

    // Single request: requester 1, word 4'b1011.
    a_data  = 16'h00B0;
    a_valid = 4'b0010;
    wait_ready(1'b0, at);
    a_valid = 4'b0000;
    check_eq("single_busy", a_busy, 32'd1);
    frame_check(1'b0, 1, 4'b1011, 1'b0, 4'b0000);
    tick();
    check_eq("single_busy_low", a_busy, 32'd0);
    check_eq("single_done_clear", a_done, 32'd0);

    // Reset mid-SHIFT: pointer is 1, so requester 2 is granted, then aborted.
    a_data  = 16'h0300;
    a_valid = 4'b0100;
    wait_ready(1'b0, at);
    check_eq("abort_grant", a_grant, 32'd2);
    tick();
    tick();
    check_eq("abort_in_frame", a_frame, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("abort_async", {a_ready, a_sout, a_frame, a_done, a_busy, a_grant}, 32'd0);
    a_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_no_done", {a_done, a_busy}, 32'd0);

    // Round robin from reset: words w0=5, w1=C, w2=6, w3=9.
    a_data  = 16'h96C5;
    a_valid = 4'b1111;
    next_frame(1'b0, 0, 4'h5, 0, 1'b0, 4'b0000);
    next_frame(1'b0, 1, 4'hC, 7, 1'b0, 4'b0000);
    next_frame(1'b0, 2, 4'h6, 7, 1'b0, 4'b0000);
    next_frame(1'b0, 3, 4'h9, 7, 1'b0, 4'b0000);
    next_frame(1'b0, 0, 4'h5, 7, 1'b0, 4'b0000);

    // Wrap and skip: move the pointer to 2, then only requesters 0 and 1 remain.
    a_valid = 4'b0100;
    next_frame(1'b0, 2, 4'h6, 7, 1'b1, 4'b0011);
    next_frame(1'b0, 0, 4'h5, 7, 1'b0, 4'b0000);
    next_frame(1'b0, 1, 4'hC, 7, 1'b0, 4'b0000);
    next_frame(1'b0, 0, 4'h5, 7, 1'b0, 4'b0000);

    // Sole requester re-granted; requester 3 arrives during its SHIFT and wins next.
    a_valid = 4'b0001;
    next_frame(1'b0, 0, 4'h5, 7, 1'b1, 4'b1001);
    next_frame(1'b0, 3, 4'h9, 7, 1'b0, 4'b0000);
    a_valid = 4'b0000;

    // GAP=0 instance: two requesters, period 6, Done lands on the IDLE cycle.
    b_data  = 16'h003A;
    b_valid = 4'b0011;
    next_frame(1'b1, 0, 4'hA, 0, 1'b0, 4'b0000);
    next_frame(1'b1, 1, 4'h3, 6, 1'b0, 4'b0000);
    next_frame(1'b1, 0, 4'hA, 6, 1'b0, 4'b0000);
    b_valid = 4'b0000;
    tick();
    tick();
    check_eq("b_idle_end", {b_busy, b_frame, b_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
